// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the IF/MEM stage logic, the shared data Memory and mem_port_arbiter.
// The arbiter uses the slave view; the pipeline/memory environment uses the master view.
interface mem_port_arbiter_if;
    logic        IReq;
    logic [31:0] IAddr;
    logic [31:0] IRData;
    logic        IReady;
    logic        DReq;
    logic        DWrite;
    logic        DIsByte;
    logic [31:0] DAddr;
    logic [31:0] DWData;
    logic [31:0] DRData;
    logic        DDone;
    logic        StallF;
    logic        StallM;
    logic [31:0] MemA;
    logic [31:0] MemWD;
    logic        MemWE;
    logic [31:0] MemRD;

    modport slave (
        input  IReq, IAddr, DReq, DWrite, DIsByte, DAddr, DWData, MemRD,
        output IRData, IReady, DRData, DDone, StallF, StallM, MemA, MemWD, MemWE
    );

    modport master (
        output IReq, IAddr, DReq, DWrite, DIsByte, DAddr, DWData, MemRD,
        input  IRData, IReady, DRData, DDone, StallF, StallM, MemA, MemWD, MemWE
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-port data Memory between instruction fetch and the memory stage.
// Byte stores run as a two-cycle read-modify-write so the byte merge never sees MemRD combinationally.
module mem_port_arbiter #(
    parameter int MAX_DATA_RUN = 3
) (
    input  logic              CLK,
    input  logic              reset,
    mem_port_arbiter_if.slave bus
);

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        RMW_WR = 1'b1
    } state_e;

    localparam logic [3:0] MAX_RUN = 4'(MAX_DATA_RUN);

    state_e      state_q, state_d;
    logic [3:0]  run_cnt_q, run_cnt_d;
    logic [31:0] rmw_word_q, rmw_word_d;
    logic [31:0] rmw_addr_q, rmw_addr_d;
    logic [7:0]  rmw_byte_q, rmw_byte_d;

    logic        forced_fetch_s;
    logic        d_grant_s;
    logic        i_grant_s;
    logic        data_cycle_s;
    logic        mem_we_s;
    logic        d_done_s;
    logic        i_ready_s;
    logic [31:0] mem_a_s;
    logic [31:0] mem_wd_s;
    logic [1:0]  iaddr_unused_s;

    function automatic logic [31:0] merge_byte(input logic [31:0] word,
                                               input logic [7:0]  data,
                                               input logic [1:0]  lane);
        logic [31:0] mask;
        mask = 32'h0000_00FF << {lane, 3'b000};
        return (word & ~mask) | ({24'h00_0000, data} << {lane, 3'b000});
    endfunction

    function automatic logic [31:0] sext_lane(input logic [31:0] word,
                                              input logic [1:0]  lane);
        logic [31:0] shifted;
        shifted = word >> {lane, 3'b000};
        return {{24{shifted[7]}}, shifted[7:0]};
    endfunction

    // State and datapath registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q    <= IDLE;
            run_cnt_q  <= 4'd0;
            rmw_word_q <= 32'h0000_0000;
            rmw_addr_q <= 32'h0000_0000;
            rmw_byte_q <= 8'h00;
        end else begin
            state_q    <= state_d;
            run_cnt_q  <= run_cnt_d;
            rmw_word_q <= rmw_word_d;
            rmw_addr_q <= rmw_addr_d;
            rmw_byte_q <= rmw_byte_d;
        end
    end

    // Grant decision: data wins in IDLE unless the fetch has been starved for MAX_DATA_RUN cycles.
    always_comb begin
        forced_fetch_s = bus.IReq & (run_cnt_q == MAX_RUN);
        if (state_q == IDLE) begin
            d_grant_s = bus.DReq & ~forced_fetch_s;
            i_grant_s = bus.IReq & ~d_grant_s;
        end else begin
            d_grant_s = 1'b0;
            i_grant_s = 1'b0;
        end
        data_cycle_s = d_grant_s | (state_q == RMW_WR);
    end

    // Next-state, starvation counter and RMW capture.
    always_comb begin
        state_d    = state_q;
        rmw_word_d = rmw_word_q;
        rmw_addr_d = rmw_addr_q;
        rmw_byte_d = rmw_byte_q;
        case (state_q)
            IDLE: begin
                if (d_grant_s & bus.DWrite & bus.DIsByte) begin
                    state_d    = RMW_WR;
                    rmw_word_d = bus.MemRD;
                    rmw_addr_d = bus.DAddr;
                    rmw_byte_d = bus.DWData[7:0];
                end else begin
                    state_d = IDLE;
                end
            end
            RMW_WR:  state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (~bus.IReq | i_grant_s) begin
            run_cnt_d = 4'd0;
        end else if (data_cycle_s & (run_cnt_q != MAX_RUN)) begin
            run_cnt_d = run_cnt_q + 4'd1;
        end else begin
            run_cnt_d = run_cnt_q;
        end
    end

    // Memory port and handshake outputs; reset masks every side effect.
    always_comb begin
        mem_a_s   = 32'h0000_0000;
        mem_wd_s  = 32'h0000_0000;
        mem_we_s  = 1'b0;
        d_done_s  = 1'b0;
        i_ready_s = 1'b0;
        case (state_q)
            IDLE: begin
                if (d_grant_s) begin
                    mem_a_s = {bus.DAddr[31:2], 2'b00};
                    if (bus.DWrite & ~bus.DIsByte) begin
                        mem_we_s = 1'b1;
                        mem_wd_s = bus.DWData;
                        d_done_s = 1'b1;
                    end else if (~bus.DWrite) begin
                        d_done_s = 1'b1;
                    end else begin
                        d_done_s = 1'b0;
                    end
                end else if (i_grant_s) begin
                    mem_a_s   = {bus.IAddr[31:2], 2'b00};
                    i_ready_s = 1'b1;
                end else begin
                    mem_a_s = 32'h0000_0000;
                end
            end
            RMW_WR: begin
                mem_a_s  = {rmw_addr_q[31:2], 2'b00};
                mem_we_s = 1'b1;
                mem_wd_s = merge_byte(rmw_word_q, rmw_byte_q, rmw_addr_q[1:0]);
                d_done_s = 1'b1;
            end
            default: begin
                mem_a_s = 32'h0000_0000;
            end
        endcase

        if (reset) begin
            mem_we_s  = 1'b0;
            d_done_s  = 1'b0;
            i_ready_s = 1'b0;
        end else begin
            mem_we_s  = mem_we_s;
        end
    end

    assign iaddr_unused_s = bus.IAddr[1:0];

    assign bus.MemA   = mem_a_s;
    assign bus.MemWD  = mem_wd_s;
    assign bus.MemWE  = mem_we_s;
    assign bus.DDone  = d_done_s;
    assign bus.IReady = i_ready_s;
    assign bus.IRData = bus.MemRD;
    assign bus.DRData = bus.DIsByte ? sext_lane(bus.MemRD, bus.DAddr[1:0]) : bus.MemRD;
    assign bus.StallF = bus.IReq & ~i_ready_s;
    assign bus.StallM = bus.DReq & ~d_done_s;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed stimulus pushes expected responses,
// a forked monitor pops and compares them whenever DDone or IReady is presented.
module tb_mem_port_arbiter;

    typedef struct packed {
        logic        is_d;
        logic        is_wr;
        logic [7:0]  id;
        logic [31:0] data;
    } exp_t;

    logic        clk;
    logic        reset;
    logic [31:0] mem [0:63];
    exp_t        exp_q[$];
    int          checks;
    int          errors;
    logic [7:0]  next_id;

    mem_port_arbiter_if bus ();

    mem_port_arbiter #(.MAX_DATA_RUN(3)) dut (
        .CLK   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: combinational read, write on the rising edge.
    assign bus.MemRD = mem[bus.MemA[7:2]];
    always @(posedge clk) begin
        if (bus.MemWE) mem[bus.MemA[7:2]] <= bus.MemWD;
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic ireq, input logic [31:0] iaddr, input logic dreq,
                         input logic dwrite, input logic dbyte, input logic [31:0] daddr,
                         input logic [31:0] dwdata);
        bus.IReq    = ireq;
        bus.IAddr   = iaddr;
        bus.DReq    = dreq;
        bus.DWrite  = dwrite;
        bus.DIsByte = dbyte;
        bus.DAddr   = daddr;
        bus.DWData  = dwdata;
    endtask

    task automatic push(input logic is_d, input logic is_wr, input logic [31:0] data);
        exp_t e;
        e.is_d  = is_d;
        e.is_wr = is_wr;
        e.id    = next_id;
        e.data  = data;
        exp_q.push_back(e);
        next_id = next_id + 8'd1;
    endtask

    task automatic monitor();
        exp_t        e;
        logic [31:0] got;
        logic        ok;
        forever begin
            @(negedge clk);
            if (!reset && (bus.DDone || bus.IReady)) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_resp: got DDone=%b IReady=%b expected no response",
                             bus.DDone, bus.IReady);
                end else begin
                    e = exp_q.pop_front();
                    if (e.is_d) begin
                        got = e.is_wr ? bus.MemWD : bus.DRData;
                        ok  = bus.DDone && !bus.IReady && (bus.MemWE == e.is_wr) && (got === e.data);
                    end else begin
                        got = bus.IRData;
                        ok  = bus.IReady && !bus.DDone && !bus.MemWE && (got === e.data);
                    end
                    if (!ok) begin
                        errors++;
                        $display("FAIL resp_%0d: got DDone=%b IReady=%b MemWE=%b data=%h expected is_d=%b is_wr=%b data=%h",
                                 e.id, bus.DDone, bus.IReady, bus.MemWE, got, e.is_d, e.is_wr, e.data);
                    end
                end
            end
        end
    endtask

    localparam logic [31:0] FETCH_WORD = 32'hCAFE_F00D;

    initial begin
        logic [31:0] lb_exp [0:3];
        checks  = 0;
        errors  = 0;
        next_id = 8'd0;
        lb_exp[0] = 32'h0000_0001;
        lb_exp[1] = 32'h0000_007F;
        lb_exp[2] = 32'hFFFF_FFFF;
        lb_exp[3] = 32'hFFFF_FF80;
        for (int i = 0; i < 64; i++) mem[i] <= 32'h0000_0000;
        mem[0]  <= FETCH_WORD;
        mem[4]  <= 32'h1122_3344;
        mem[8]  <= 32'h80FF_7F01;
        mem[12] <= 32'hAABB_CCDD;
        mem[16] <= 32'h0102_0304;

        reset = 1'b1;
        drive(1'b1, 32'h0, 1'b1, 1'b1, 1'b0, 32'h44, 32'h5555_5555);
        fork
            monitor();
        join_none

        // Reset: side effects masked, both requesters stalled.
        next_cycle();
        @(negedge clk);
        chk("rst_memwe",  {31'd0, bus.MemWE},  32'd0);
        chk("rst_ddone",  {31'd0, bus.DDone},  32'd0);
        chk("rst_iready", {31'd0, bus.IReady}, 32'd0);
        chk("rst_stallf", {31'd0, bus.StallF}, 32'd1);
        chk("rst_stallm", {31'd0, bus.StallM}, 32'd1);
        next_cycle();
        reset = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        next_cycle();

        // Word load with idle fetch.
        drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h10, 32'h0);
        push(1'b1, 1'b0, 32'h1122_3344);
        @(negedge clk);
        chk("wl_stallm", {31'd0, bus.StallM}, 32'd0);
        chk("wl_mema",   bus.MemA, 32'h10);
        next_cycle();

        // Byte loads across all four lanes.
        for (int l = 0; l < 4; l++) begin
            drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 32'h20 + 32'(l), 32'h0);
            push(1'b1, 1'b0, lb_exp[l]);
            next_cycle();
        end

        // Byte store RMW on lane 2.
        drive(1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 32'h32, 32'h1234_5699);
        @(negedge clk);
        chk("sb_rd_memwe",  {31'd0, bus.MemWE},  32'd0);
        chk("sb_rd_stallm", {31'd0, bus.StallM}, 32'd1);
        push(1'b1, 1'b1, 32'hAA99_CCDD);
        next_cycle();
        @(negedge clk);
        chk("sb_wr_stallm", {31'd0, bus.StallM}, 32'd0);
        next_cycle();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        chk("sb_mem", mem[12], 32'hAA99_CCDD);
        next_cycle();
        drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h30, 32'h0);
        push(1'b1, 1'b0, 32'hAA99_CCDD);
        next_cycle();

        // Contention: D,D,D,I,D,D with MAX_DATA_RUN=3.
        for (int c = 0; c < 6; c++) begin
            drive(1'b1, 32'h0, 1'b1, 1'b0, 1'b0, 32'h10, 32'h0);
            if (c == 3) push(1'b0, 1'b0, FETCH_WORD);
            else        push(1'b1, 1'b0, 32'h1122_3344);
            @(negedge clk);
            chk($sformatf("fair_stallf_%0d", c), {31'd0, bus.StallF}, (c == 3) ? 32'd0 : 32'd1);
            next_cycle();
        end
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        next_cycle();

        // Reset during the write phase of a byte store.
        drive(1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 32'h40, 32'h0000_00FF);
        @(negedge clk);
        chk("rrmw_rd_ddone", {31'd0, bus.DDone}, 32'd0);
        next_cycle();
        reset = 1'b1;
        @(negedge clk);
        chk("rrmw_memwe", {31'd0, bus.MemWE}, 32'd0);
        chk("rrmw_ddone", {31'd0, bus.DDone}, 32'd0);
        next_cycle();
        reset = 1'b0;
        chk("rrmw_mem", mem[16], 32'h0102_0304);
        drive(1'b1, 32'h0, 1'b1, 1'b0, 1'b0, 32'h40, 32'h0);
        push(1'b1, 1'b0, 32'h0102_0304);
        next_cycle();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        next_cycle();

        // Word store while fetching, then fetch, then read back.
        drive(1'b1, 32'h0, 1'b1, 1'b1, 1'b0, 32'h44, 32'hDEAD_BEEF);
        push(1'b1, 1'b1, 32'hDEAD_BEEF);
        @(negedge clk);
        chk("sw_stallf", {31'd0, bus.StallF}, 32'd1);
        next_cycle();
        drive(1'b1, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        push(1'b0, 1'b0, FETCH_WORD);
        @(negedge clk);
        chk("sw_iready", {31'd0, bus.IReady}, 32'd1);
        next_cycle();
        drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h44, 32'h0);
        push(1'b1, 1'b0, 32'hDEAD_BEEF);
        next_cycle();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        next_cycle();
        next_cycle();

        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single-port data `Memory` between the instruction-fetch stage and the memory stage of the pipeline. It grants one requester per cycle and stalls the other. Byte stores (`sb`) are sequenced as a two-cycle read-modify-write, which removes the combinational `RD`→`WD` loop of the byte-masking path. The block sits between the `IF`/`MEM` stage logic and the `Memory` instance and produces the fetch and memory stall signals for the hazard unit.

## Interface
- `MAX_DATA_RUN`, default 3: number of consecutive data grants allowed while a fetch is pending before one fetch grant is forced. Range 1–15.
- `CLK` in 1: rising-edge clock.
- `reset` in 1: synchronous, active-high.
- `IReq` in 1: fetch stage requests an instruction word.
- `IAddr` in 32: fetch byte address. Bits [1:0] are ignored.
- `IRData` out 32: fetched word. Valid when `IReady`=1.
- `IReady` out 1: fetch granted this cycle.
- `DReq` in 1: memory stage access (`MemtoRegM | MemWriteM`).
- `DWrite` in 1: 1 = store, 0 = load.
- `DIsByte` in 1: byte access (`lb`/`sb`).
- `DAddr` in 32: data byte address. Bits [1:0] give the byte lane.
- `DWData` in 32: store data. Only bits [7:0] are used for byte stores.
- `DRData` out 32: load result. Byte loads are sign-extended from the selected lane.
- `DDone` out 1: data access completes this cycle.
- `StallF` out 1: `IReq & ~IReady`.
- `StallM` out 1: `DReq & ~DDone`.
- `MemA` out 32: word address to `Memory`, always `{addr[31:2],2'b00}`.
- `MemWD` out 32: write data to `Memory`.
- `MemWE` out 1: write enable to `Memory`. `Memory` writes on the rising edge.
- `MemRD` in 32: combinational read data from `Memory`.

## Operation
- FSM states:
  - `IDLE`: normal arbitration.
  - `RMW_WR`: write phase of a byte store.
- Grant in `IDLE`:
  - If `DReq` and not forced-fetch: data granted.
  - Else if `IReq`: fetch granted.
  - Forced-fetch condition: `IReq & (run_cnt == MAX_DATA_RUN)`.
- `run_cnt` (4 bits):
  - Increments on each cycle a data grant occurs while `IReq`=1.
  - Clears on any fetch grant or any cycle with `IReq`=0.
  - Saturates at `MAX_DATA_RUN`.
  - Cycles in `RMW_WR` count as data grants.
- Data grant, word load: `MemA`=`DAddr` aligned, `DRData`=`MemRD`, `DDone`=1.
- Data grant, byte load: `DRData` = sign-extend(`MemRD >> 8*DAddr[1:0]`, bits [7:0]), `DDone`=1.
- Data grant, word store: `MemWE`=1, `MemWD`=`DWData`, `DDone`=1.
- Data grant, byte store, read phase (in `IDLE`):
  - `MemWE`=0, `DDone`=0.
  - At the clock edge: latch `rmw_word`←`MemRD`, `rmw_addr`←`DAddr`, `rmw_byte`←`DWData[7:0]`.
  - Go to `RMW_WR`.
- `RMW_WR`:
  - `MemA`=`rmw_addr` aligned, `MemWE`=1, `DDone`=1.
  - `MemWD` = (`rmw_word` & ~(`FF`<<8·lane)) | (`rmw_byte`<<8·lane).
  - Return to `IDLE`.
  - The write completes even if `DReq` drops. The caller must hold `DReq` until `DDone`.
- Fetch grant: `MemA`=`IAddr` aligned, `IRData`=`MemRD`, `IReady`=1, `MemWE`=0.
- No grant: `MemA`=0, `MemWE`=0, `DDone`=0, `IReady`=0.
- `DRData` and `IRData` carry `MemRD`-derived values every cycle. They are meaningful only with `DDone`/`IReady`.

## Timing
- Reset (synchronous): state←`IDLE`, `run_cnt`←0, `rmw_word`/`rmw_addr`/`rmw_byte`←0.
- While `reset`=1, the following are forced low combinationally: `MemWE`, `DDone`, `IReady`. `StallF`=`IReq`, `StallM`=`DReq`.
- Latency:
  - Load, word store, fetch: 0 extra cycles (done in the grant cycle).
  - Byte store: `DDone` in the 2nd cycle.
  - A lost arbitration adds one cycle per lost grant.
- Reset asserted in `RMW_WR`: no write occurs and the FSM returns to `IDLE`.
- Fetch is never granted in `RMW_WR`. `StallF`=`IReq` there.
- Back-to-back byte stores: `IDLE`→`RMW_WR`→`IDLE`→`RMW_WR`. There is no idle cycle between them except a forced fetch.
- Only one of `IReady`, `DDone` is high per cycle, except with `DDone`=0 during the RMW read phase.
- `MemWE` is high only in word-store grant cycles and `RMW_WR`.

## Test plan
- **Word load with idle fetch:** mem[0x10]=0x11223344; `DReq`=1, `DAddr`=0x10, `DWrite`=0 → same cycle `DDone`=1, `DRData`=0x11223344, `StallM`=0.
- **Byte load, sign extend:** mem[0x20]=0x80FF7F01; `lb` at 0x21 → `DRData`=0x0000007F; at 0x22 → 0xFFFFFFFF; at 0x23 → 0xFFFFFF80.
- **Byte store RMW:** mem[0x30]=0xAABBCCDD; `sb` `DAddr`=0x32, `DWData`=0x12345699.
  - Cycle 1: `MemWE`=0, `StallM`=1.
  - Cycle 2: `MemWE`=1, `MemWD`=0xAA99CCDD, `DDone`=1.
  - Afterwards mem[0x30] reads 0xAA99CCDD.
- **Contention / fairness (`MAX_DATA_RUN`=3):** `IReq` and `DReq` held high with word loads for 6 cycles → grants D,D,D,I,D,D. `StallF` is high on every data cycle. `IReady`=1 only in cycle 4.
- **Reset mid-RMW:** start `sb` at 0x40 (mem=0x01020304), assert `reset` in the `RMW_WR` cycle → `MemWE`=0, mem[0x40] unchanged at 0x01020304, next cycle state `IDLE` with `run_cnt`=0.
- **Word store while fetching:** `IReq`=1 with `IAddr`=0x0; `sw` 0xDEADBEEF to 0x44 → cycle 1: `MemWE`=1, `StallF`=1. Cycle 2 (`DReq`=0): `IReady`=1. A later load from 0x44 returns 0xDEADBEEF.
